// File: rtl/input_arbiter.sv
// input_arbiter: selects one of NUM_CH valid/ready input channels, either by a
// fixed select index or by round-robin, and loads the winning word into a
// single-entry output register. A drain and a refill may happen on the same
// edge, so a continuously ready sink sees one word per cycle.
module input_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 4,
    localparam int SEL_W     = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mode,
    input  logic [SEL_W-1:0]             sel,
    input  logic [NUM_CH-1:0]            in_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]            in_ready,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]             out_ch,
    input  logic                         out_ready
);

    // Channel count widened by one bit so pointer sums up to 2*NUM_CH-1 fit.
    localparam logic [SEL_W:0]   NUM_CH_EXT = (SEL_W+1)'(NUM_CH);
    // After reset the pointer sits on the last channel so channel 0 wins first.
    localparam logic [SEL_W-1:0] PTR_RST    = SEL_W'(NUM_CH - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic [DATA_WIDTH-1:0]   out_data_reg, out_data_next;
    logic [SEL_W-1:0]        out_ch_reg, out_ch_next;
    logic [SEL_W-1:0]        ptr_reg, ptr_next;

    logic [DATA_WIDTH-1:0]   ch_data [NUM_CH];
    logic [SEL_W-1:0]        rr_idx  [NUM_CH];
    logic [NUM_CH-1:0]       rr_hit;
    logic [NUM_CH-1:0]       fx_hit;

    logic                    gnt_valid;
    logic [SEL_W-1:0]        gnt_idx;
    logic                    can_accept;
    logic                    take;

    // Unpack the flattened input bus into one word per channel.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
        assign ch_data[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Candidate gi of the round-robin search is channel (ptr + 1 + gi) mod
    // NUM_CH. The pointer never exceeds NUM_CH-1, so a single conditional
    // subtraction performs the wrap for any channel count.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rr
        logic [SEL_W:0] sum;
        logic [SEL_W:0] wrapped;
        assign sum         = {1'b0, ptr_reg} + (SEL_W+1)'(gi + 1);
        assign wrapped     = (sum >= NUM_CH_EXT) ? (sum - NUM_CH_EXT) : sum;
        assign rr_idx[gi]  = wrapped[SEL_W-1:0];
        assign rr_hit[gi]  = in_valid[rr_idx[gi]];
    end

    // Fixed select: a select value at or beyond NUM_CH matches no channel.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_fixed
        assign fx_hit[gi] = in_valid[gi] && (sel == SEL_W'(gi));
    end

    // Grant resolution; descending scan so the lowest candidate slot wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        if (!mode) begin
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                if (fx_hit[k]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = SEL_W'(k);
                end
            end
        end else begin
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                if (rr_hit[k]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = rr_idx[k];
                end
            end
        end
    end

    // The register can take a word when empty or when its word leaves now.
    // Reset forces every ready low even though the register reads as empty.
    assign out_valid  = (state_reg == FULL);
    assign can_accept = (state_reg == EMPTY) || (out_valid && out_ready);
    assign take       = gnt_valid && can_accept && !rst;

    // One-hot accept strobe towards the granted channel only.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ready
        assign in_ready[gi] = take && (gnt_idx == SEL_W'(gi));
    end

    // Next-state logic: load on a transfer, empty on a drain without refill.
    always_comb begin
        state_next    = state_reg;
        out_data_next = out_data_reg;
        out_ch_next   = out_ch_reg;
        ptr_next      = ptr_reg;
        case (state_reg)
            EMPTY: begin
                if (take) begin
                    state_next    = FULL;
                    out_data_next = ch_data[gnt_idx];
                    out_ch_next   = gnt_idx;
                end
            end
            FULL: begin
                if (take) begin
                    state_next    = FULL;
                    out_data_next = ch_data[gnt_idx];
                    out_ch_next   = gnt_idx;
                end else if (out_ready) begin
                    // Word leaves with nothing to replace it; data and
                    // channel keep their last values.
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
        // Only round-robin transfers move the pointer.
        if (take && mode) begin
            ptr_next = gnt_idx;
        end
    end

    // State registers; reset clears the held word without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= EMPTY;
            out_data_reg <= '0;
            out_ch_reg   <= '0;
            ptr_reg      <= PTR_RST;
        end else begin
            state_reg    <= state_next;
            out_data_reg <= out_data_next;
            out_ch_reg   <= out_ch_next;
            ptr_reg      <= ptr_next;
        end
    end

    assign out_data = out_data_reg;
    assign out_ch   = out_ch_reg;

endmodule

// File: tb/tb_input_arbiter.sv
// Testbench for input_arbiter: a 4-channel instance driven by a vector table,
// an asynchronous reset sequence and randomized traffic against a reference
// model, plus a 3-channel instance for wrap and out-of-range select cases.
module tb_input_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // 4-channel instance
    logic        mode4, ordy4;
    logic [1:0]  sel4;
    logic [3:0]  valid4, ir4;
    logic [31:0] data4;
    logic        ov4;
    logic [7:0]  od4;
    logic [1:0]  oc4;

    // 3-channel instance
    logic        mode3, ordy3;
    logic [1:0]  sel3;
    logic [2:0]  valid3, ir3;
    logic [23:0] data3;
    logic        ov3;
    logic [7:0]  od3;
    logic [1:0]  oc3;

    input_arbiter #(.DATA_WIDTH(8), .NUM_CH(4)) dut4 (
        .clk(clk), .rst(rst), .mode(mode4), .sel(sel4),
        .in_valid(valid4), .in_data(data4), .in_ready(ir4),
        .out_valid(ov4), .out_data(od4), .out_ch(oc4), .out_ready(ordy4)
    );

    input_arbiter #(.DATA_WIDTH(8), .NUM_CH(3)) dut3 (
        .clk(clk), .rst(rst), .mode(mode3), .sel(sel3),
        .in_valid(valid3), .in_data(data3), .in_ready(ir3),
        .out_valid(ov3), .out_data(od3), .out_ch(oc3), .out_ready(ordy3)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    endtask

    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        ordy;
        logic [3:0]  exp_ir;
        logic        exp_ov;
        logic [7:0]  exp_od;
        logic [1:0]  exp_oc;
    } vec_t;

    localparam logic [31:0] D_RR = 32'h13121110;
    localparam logic [31:0] D_FX = 32'h13A51110;

    vec_t vecs [19];

    // Entered just after a rising edge: drive, check ready, clock, check output.
    task automatic apply4(input vec_t v, input int i);
        mode4 = v.mode; sel4 = v.sel; valid4 = v.valid; data4 = v.data; ordy4 = v.ordy;
        #2;
        chk($sformatf("vec%0d_in_ready", i), ir4, v.exp_ir);
        @(posedge clk); #1;
        chk($sformatf("vec%0d_out_valid", i), ov4, v.exp_ov);
        chk($sformatf("vec%0d_out_data", i), od4, v.exp_od);
        chk($sformatf("vec%0d_out_ch", i), oc4, v.exp_oc);
        $display("vec%0d mode=%0d sel=%0d valid=%b ordy=%0d -> ready=%b ov=%0d data=%h ch=%0d",
                 i, v.mode, v.sel, v.valid, v.ordy, ir4, ov4, od4, oc4);
    endtask

    task automatic apply3(input string name, input logic m, input logic [1:0] s,
                          input logic [2:0] v, input logic r, input logic [2:0] e_ir,
                          input logic e_ov, input logic [7:0] e_od, input logic [1:0] e_oc);
        mode3 = m; sel3 = s; valid3 = v; ordy3 = r;
        #2;
        chk({name, "_in_ready"}, ir3, e_ir);
        @(posedge clk); #1;
        chk({name, "_out_valid"}, ov3, e_ov);
        chk({name, "_out_data"}, od3, e_od);
        chk({name, "_out_ch"}, oc3, e_oc);
        $display("%s ready=%b ov=%0d data=%h ch=%0d", name, ir3, ov3, od3, oc3);
    endtask

    // Reference model of the 4-channel instance.
    bit         m_full;
    logic [7:0] m_data;
    int         m_ch;
    int         m_ptr;

    task automatic rand_step4(input int n);
        int g;
        int idx;
        bit can;
        logic [3:0] exp_ir;
        mode4  = 1'($urandom_range(0, 1));
        sel4   = 2'($urandom_range(0, 3));
        valid4 = 4'($urandom_range(0, 15));
        data4  = $urandom;
        ordy4  = ($urandom_range(0, 3) != 0);
        g = -1;
        if (!mode4) begin
            if (valid4[sel4]) g = int'(sel4);
        end else begin
            for (int k = 1; k <= 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (valid4[idx]) begin
                    g = idx;
                    break;
                end
            end
        end
        can = !m_full || ordy4;
        exp_ir = '0;
        if (can && g >= 0) exp_ir[g] = 1'b1;
        #2;
        chk($sformatf("rand%0d_in_ready", n), ir4, exp_ir);
        if (can && g >= 0) begin
            m_full = 1'b1;
            m_data = data4[g*8 +: 8];
            m_ch   = g;
            if (mode4) m_ptr = g;
        end else if (m_full && ordy4) begin
            m_full = 1'b0;
        end
        @(posedge clk); #1;
        chk($sformatf("rand%0d_out_valid", n), ov4, m_full);
        chk($sformatf("rand%0d_out_data", n), od4, m_data);
        chk($sformatf("rand%0d_out_ch", n), oc4, m_ch);
        $display("rand%0d mode=%0d sel=%0d valid=%b ordy=%0d -> ready=%b ov=%0d data=%h ch=%0d",
                 n, mode4, sel4, valid4, ordy4, ir4, ov4, od4, oc4);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 2'd2, 4'b1111, D_FX, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
        vecs[1]  = '{1'b1, 2'd0, 4'b1111, D_RR, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
        vecs[2]  = '{1'b1, 2'd0, 4'b1111, D_RR, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
        vecs[3]  = '{1'b1, 2'd0, 4'b1111, D_RR, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
        vecs[4]  = '{1'b1, 2'd0, 4'b1111, D_RR, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
        vecs[5]  = '{1'b1, 2'd0, 4'b1111, D_RR, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
        vecs[6]  = '{1'b1, 2'd0, 4'b1111, D_RR, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
        vecs[7]  = '{1'b1, 2'd0, 4'b1111, D_RR, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
        vecs[8]  = '{1'b1, 2'd0, 4'b1111, D_RR, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
        vecs[9]  = '{1'b1, 2'd0, 4'b1111, D_RR, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
        vecs[10] = '{1'b1, 2'd0, 4'b1000, D_RR, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
        vecs[11] = '{1'b1, 2'd0, 4'b0000, D_RR, 1'b1, 4'b0000, 1'b0, 8'h13, 2'd3};
        vecs[12] = '{1'b1, 2'd0, 4'b0000, D_RR, 1'b0, 4'b0000, 1'b0, 8'h13, 2'd3};
        vecs[13] = '{1'b1, 2'd0, 4'b0010, D_RR, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
        vecs[14] = '{1'b1, 2'd0, 4'b0001, D_RR, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
        vecs[15] = '{1'b0, 2'd1, 4'b1101, D_RR, 1'b1, 4'b0000, 1'b0, 8'h10, 2'd0};
        vecs[16] = '{1'b0, 2'd3, 4'b1000, D_RR, 1'b0, 4'b1000, 1'b1, 8'h13, 2'd3};
        vecs[17] = '{1'b1, 2'd0, 4'b1111, D_RR, 1'b0, 4'b0000, 1'b1, 8'h13, 2'd3};
        vecs[18] = '{1'b1, 2'd0, 4'b1111, D_RR, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};

        // Reset with all channels requesting: nothing may be accepted.
        rst = 1'b1;
        mode4 = 1'b1; sel4 = 2'd0; valid4 = 4'b1111; data4 = D_RR; ordy4 = 1'b1;
        mode3 = 1'b1; sel3 = 2'd0; valid3 = 3'b111; data3 = 24'h323130; ordy3 = 1'b1;
        #2;
        chk("reset_in_ready4", ir4, 4'b0000);
        chk("reset_out_valid4", ov4, 1'b0);
        chk("reset_out_data4", od4, 8'h00);
        chk("reset_out_ch4", oc4, 2'd0);
        chk("reset_in_ready3", ir3, 3'b000);
        chk("reset_out_valid3", ov3, 1'b0);
        @(posedge clk); #1;
        chk("reset_hold_out_valid4", ov4, 1'b0);
        $display("reset ready=%b ov=%0d data=%h ch=%0d", ir4, ov4, od4, oc4);
        valid3 = 3'b000;
        rst = 1'b0;
        #1;
        chk("post_reset_first_grant", ir4, 4'b0001);

        for (int i = 0; i < 19; i++) apply4(vecs[i], i);

        // Mid-cycle reset while holding a word.
        #3 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", ov4, 1'b0);
        chk("async_rst_out_data", od4, 8'h00);
        chk("async_rst_out_ch", oc4, 2'd0);
        chk("async_rst_in_ready", ir4, 4'b0000);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_next_grant", ir4, 4'b0001);
        @(posedge clk); #1;
        chk("async_rst_refill_valid", ov4, 1'b1);
        chk("async_rst_refill_data", od4, 8'h10);
        chk("async_rst_refill_ch", oc4, 2'd0);
        $display("async_rst ov=%0d data=%h ch=%0d", ov4, od4, oc4);

        m_full = 1'b1; m_data = 8'h10; m_ch = 0; m_ptr = 0;
        for (int n = 0; n < 400; n++) rand_step4(n);
        valid4 = 4'b0000;

        // Three-channel instance: out-of-range select, then round-robin wrap.
        apply3("n3_sel3",  1'b0, 2'd3, 3'b111, 1'b1, 3'b000, 1'b0, 8'h00, 2'd0);
        apply3("n3_rr0",   1'b1, 2'd0, 3'b111, 1'b1, 3'b001, 1'b1, 8'h30, 2'd0);
        apply3("n3_rr1",   1'b1, 2'd0, 3'b111, 1'b1, 3'b010, 1'b1, 8'h31, 2'd1);
        apply3("n3_rr2",   1'b1, 2'd0, 3'b111, 1'b1, 3'b100, 1'b1, 8'h32, 2'd2);
        apply3("n3_rr3",   1'b1, 2'd0, 3'b111, 1'b1, 3'b001, 1'b1, 8'h30, 2'd0);
        apply3("n3_drain", 1'b0, 2'd3, 3'b111, 1'b1, 3'b000, 1'b0, 8'h30, 2'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
